blinky_pio_in: RTL

Parametrised Avalon-MM input PIO for the blinky system: samples a WIDTH-bit asynchronous `in_port`, synchronises and debounces each bit, latches per-bit edge events, and raises a maskable interrupt. It replaces fixed-width, read-only input ports on the system interconnect, such as the switch and key inputs. A 1-cycle read latency keeps it compatible with existing software.

---
 rtl/blinky_pio_pkg.sv | 26 ++
 rtl/blinky_pio_debounce.sv | 71 +++++++
 rtl/blinky_pio_in.sv | 87 ++++++++
 3 files changed

// File: rtl/blinky_pio_pkg.sv
// Shared definitions for the blinky input PIO.
// Register offsets, edge selection codes and counter sizing.
package blinky_pio_pkg;

    typedef enum logic [1:0] {
        PIO_DATA     = 2'd0,
        PIO_RSVD     = 2'd1,
        PIO_IRQ_MASK = 2'd2,
        PIO_EDGECAP  = 2'd3
    } pio_reg_e;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Bits needed to hold values 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/blinky_pio_debounce.sv
// One input bit: two-flop synchroniser, stability counter, debounced
// level and a single-cycle pulse on the selected debounced edge.
module blinky_pio_debounce
    import blinky_pio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = EDGE_RISE
) (
    input  logic clk,
    input  logic reset,
    input  logic in_i,
    output logic db_o,
    output logic edge_o
);

    localparam int CW = clog2(DEBOUNCE_CYCLES + 1);
    localparam int TH = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TH - 1);

    logic          s1_q;
    logic          s2_q;
    logic          db_q;
    logic          db_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          rise;
    logic          fall;

    // The count restarts whenever the synchronised level agrees with db.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (s2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = s2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            cnt_q <= '0;
            db_q  <= 1'b0;
        end else begin
            s1_q  <= in_i;
            s2_q  <= s1_q;
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end

    assign rise = db_d & ~db_q;
    assign fall = ~db_d & db_q;

    always_comb begin
        edge_o = 1'b0;
        case (EDGE_TYPE)
            EDGE_RISE: edge_o = rise;
            EDGE_FALL: edge_o = fall;
            EDGE_ANY:  edge_o = rise | fall;
            default:   edge_o = 1'b0;
        endcase
    end

    assign db_o = db_q;

endmodule

// File: rtl/blinky_pio_in.sv
// Avalon-MM input PIO: debounced inputs, edge capture with W1C clear,
// interrupt mask and a registered read mux with one cycle of latency.
module blinky_pio_in
    import blinky_pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] db;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] cap_d;
    logic [31:0]      rdata_q;
    logic [31:0]      rdata_d;
    logic             wr_en;
    logic [31:0]      unused_wdata;

    assign unused_wdata = writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        blinky_pio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .EDGE_TYPE      (EDGE_TYPE)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .in_i  (in_port[i]),
            .db_o  (db[i]),
            .edge_o(edge_set[i])
        );
    end

    assign wr_en = chipselect & write;

    // A fresh edge is ORed in after the clear so it is never lost.
    always_comb begin
        mask_d = mask_q;
        cap_d  = cap_q;
        if (wr_en && (address == PIO_IRQ_MASK)) begin
            mask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && (address == PIO_EDGECAP)) begin
            cap_d = cap_q & ~writedata[WIDTH-1:0];
        end
        cap_d = cap_d | edge_set;
    end

    always_comb begin
        rdata_d = '0;
        unique case (pio_reg_e'(address))
            PIO_DATA:     rdata_d[WIDTH-1:0] = db;
            PIO_RSVD:     rdata_d = '0;
            PIO_IRQ_MASK: rdata_d[WIDTH-1:0] = mask_q;
            PIO_EDGECAP:  rdata_d[WIDTH-1:0] = cap_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q  <= '0;
            cap_q   <= '0;
            rdata_q <= '0;
        end else begin
            mask_q  <= mask_d;
            cap_q   <= cap_d;
            rdata_q <= rdata_d;
        end
    end

    assign readdata = rdata_q;
    assign irq      = |(cap_q & mask_q);

endmodule
